// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Define FETCH_DELAY_SLOT_EN to build the MIPS-style branch-delay-slot variant.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        id_valid_r, id_valid_s;
    logic [31:0] id_inst_r, id_inst_s;
    logic [31:0] id_pc_r, id_pc_s;
    logic [31:0] id_pc_plus4_r, id_pc_plus4_s;
    logic        halted_r, halted_s;
    logic        fault_r, fault_s;
    logic [31:0] pc_plus4_s;
    logic        redir_ok_s, redir_bad_s, capture_s, squash_s;
`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_valid_r, pend_valid_s;
    logic [31:0] pend_pc_r, pend_pc_s;
`endif

    // Next-state, PC and IF/ID selection.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        id_valid_s    = id_valid_r;
        id_inst_s     = id_inst_r;
        id_pc_s       = id_pc_r;
        id_pc_plus4_s = id_pc_plus4_r;
        halted_s      = halted_r;
        fault_s       = fault_r;
        capture_s     = 1'b0;
        squash_s      = 1'b0;
        pc_plus4_s    = pc_r + 32'd4;
        redir_ok_s    = redirect_valid && (redirect_pc[1:0] == 2'b00);
        redir_bad_s   = redirect_valid && (redirect_pc[1:0] != 2'b00);
`ifdef FETCH_DELAY_SLOT_EN
        pend_valid_s  = pend_valid_r;
        pend_pc_s     = pend_pc_r;
`endif
        case (state_r)
            ST_RUN: begin
                if (redir_bad_s) begin
                    state_s    = ST_FAULT;
                    fault_s    = 1'b1;
                    id_valid_s = 1'b0;
                end else begin
`ifdef FETCH_DELAY_SLOT_EN
                    // A stalled redirect parks its target until the slot is captured.
                    if (stall) begin
                        if (redir_ok_s) begin
                            pend_valid_s = 1'b1;
                            pend_pc_s    = redirect_pc;
                        end else begin
                            pend_valid_s = pend_valid_r;
                        end
                    end else begin
                        capture_s    = 1'b1;
                        pend_valid_s = 1'b0;
                        if (redir_ok_s) begin
                            pc_s = redirect_pc;
                        end else if (pend_valid_r) begin
                            pc_s = pend_pc_r;
                        end else begin
                            pc_s = pc_plus4_s;
                        end
                    end
`else
                    if (redir_ok_s) begin
                        pc_s     = redirect_pc;
                        squash_s = !stall;
                    end else if (!stall) begin
                        pc_s      = pc_plus4_s;
                        capture_s = 1'b1;
                    end else begin
                        pc_s = pc_r;
                    end
`endif
                    if (flush || squash_s) begin
                        id_valid_s = 1'b0;
                        id_inst_s  = 32'd0;
                    end else if (capture_s) begin
                        id_valid_s    = 1'b1;
                        id_inst_s     = imem_data;
                        id_pc_s       = pc_r;
                        id_pc_plus4_s = pc_plus4_s;
                    end else begin
                        id_valid_s = id_valid_r;
                    end
                    if (capture_s && !flush && (imem_data == HALT_WORD)) begin
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                        pc_s     = pc_r;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                id_valid_s = 1'b0;
                if (flush) begin
                    id_inst_s = 32'd0;
                end else begin
                    id_inst_s = id_inst_r;
                end
            end
            ST_FAULT: begin
                id_valid_s = 1'b0;
            end
            default: begin
                state_s    = ST_FAULT;
                fault_s    = 1'b1;
                id_valid_s = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            id_valid_r    <= 1'b0;
            id_inst_r     <= 32'd0;
            id_pc_r       <= 32'd0;
            id_pc_plus4_r <= 32'd0;
            halted_r      <= 1'b0;
            fault_r       <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid_r  <= 1'b0;
            pend_pc_r     <= 32'd0;
`endif
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            id_valid_r    <= id_valid_s;
            id_inst_r     <= id_inst_s;
            id_pc_r       <= id_pc_s;
            id_pc_plus4_r <= id_pc_plus4_s;
            halted_r      <= halted_s;
            fault_r       <= fault_s;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid_r  <= pend_valid_s;
            pend_pc_r     <= pend_pc_s;
`endif
        end
    end

    assign imem_addr   = pc_r;
    assign id_valid    = id_valid_r;
    assign id_inst     = id_inst_r;
    assign id_pc       = id_pc_r;
    assign id_pc_plus4 = id_pc_plus4_r;
    assign halted      = halted_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stimulus against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'h0000_000C;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
    logic        fault;

    logic [31:0] rom [0:63];
    int          n_checks = 0;
    int          n_errors = 0;

    // reference model state
    logic [31:0] m_pc, m_inst, m_idpc, m_idpc4;
    logic        m_valid, m_halted, m_fault;
`ifdef FETCH_DELAY_SLOT_EN
    logic        m_pend_v;
    logic [31:0] m_pend;
`endif

    fetch_stage #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .halted         (halted),
        .fault          (fault)
    );

    always_comb imem_data = rom[imem_addr[7:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_inst = 32'd0; m_idpc = 32'd0; m_idpc4 = 32'd0;
        m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
        m_pend_v = 1'b0; m_pend = 32'd0;
`endif
    endtask

    task automatic model_step(input logic st, input logic fl, input logic rv, input logic [31:0] rp);
        logic [31:0] word, next_pc;
        logic        take, bubble;
        word = rom[m_pc[7:2]];
        take = 1'b0; bubble = 1'b0; next_pc = m_pc;
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
            if (fl) m_inst = 32'd0;
        end else if (rv && (rp[1:0] != 2'b00)) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
        end else begin
`ifdef FETCH_DELAY_SLOT_EN
            if (st) begin
                if (rv) begin m_pend_v = 1'b1; m_pend = rp; end
            end else begin
                take = 1'b1;
                next_pc = rv ? rp : (m_pend_v ? m_pend : m_pc + 32'd4);
                m_pend_v = 1'b0;
            end
`else
            if (rv) next_pc = rp;
            else if (!st) begin next_pc = m_pc + 32'd4; take = 1'b1; end
            bubble = rv && !st;
`endif
            if (fl || bubble) begin
                m_valid = 1'b0; m_inst = 32'd0;
            end else if (take) begin
                m_valid = 1'b1; m_inst = word; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
            end
            if (take && !fl && word == HALT_WORD) begin
                m_halted = 1'b1;
                next_pc = m_pc;
            end
            m_pc = next_pc;
        end
    endtask

    task automatic compare_model();
        check("m_imem_addr", imem_addr, m_pc);
        check("m_id_valid", 32'(id_valid), 32'(m_valid));
        check("m_halted", 32'(halted), 32'(m_halted));
        check("m_fault", 32'(fault), 32'(m_fault));
        if (m_valid) begin
            check("m_id_inst", id_inst, m_inst);
            check("m_id_pc", id_pc, m_idpc);
            check("m_id_pc_plus4", id_pc_plus4, m_idpc4);
        end
    endtask

    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rp);
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rp;
        model_step(st, fl, rv, rp);
        @(posedge clock);
        #1;
        compare_model();
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic fill_rom(input int halt_odds);
        for (int i = 0; i < 64; i++) begin
            if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) rom[i] = HALT_WORD;
            else rom[i] = $urandom | 32'h8000_0000;
        end
    endtask

    initial begin
        logic [31:0] rp;
        logic        st, fl, rv;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        fill_rom(0);
        model_reset();
        #2;
        check("init_imem_addr", imem_addr, RESET_PC);
        check("init_id_valid", 32'(id_valid), 32'd0);
        check("init_id_inst", id_inst, 32'd0);
        check("init_id_pc", id_pc, 32'd0);
        check("init_id_pc_plus4", id_pc_plus4, 32'd0);
        check("init_halted", 32'(halted), 32'd0);
        check("init_fault", 32'(fault), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // first captures after reset release
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("e1_id_pc", id_pc, 32'h0);
        check("e1_id_inst", id_inst, rom[0]);
        check("e1_id_valid", 32'(id_valid), 32'd1);
        check("e1_id_pc_plus4", id_pc_plus4, 32'h4);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("e2_id_pc", id_pc, 32'h4);
        check("e2_imem_addr", imem_addr, 32'h8);

        // stall holds PC and IF/ID
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            check("stall_imem_addr", imem_addr, 32'h8);
            check("stall_id_pc", id_pc, 32'h4);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("unstall_id_pc", id_pc, 32'h8);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("stallflush_id_valid", 32'(id_valid), 32'd0);
        check("stallflush_id_inst", id_inst, 32'd0);
        check("stallflush_imem_addr", imem_addr, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("pre_redir_imem_addr", imem_addr, 32'h10);

        // redirect at 0x10 to 0x40
        step(1'b0, 1'b0, 1'b1, 32'h40);
        check("redir_imem_addr", imem_addr, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
        check("redir_slot_valid", 32'(id_valid), 32'd1);
        check("redir_slot_pc", id_pc, 32'h10);
`else
        check("redir_squash_valid", 32'(id_valid), 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("redir_target_pc", id_pc, 32'h40);

        // redirect under stall
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h40);
        step(1'b1, 1'b0, 1'b0, 32'd0);
`ifdef FETCH_DELAY_SLOT_EN
        check("pend_imem_addr", imem_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("pend_slot_pc", id_pc, 32'h10);
        check("pend_target_addr", imem_addr, 32'h40);
`else
        check("stallredir_imem_addr", imem_addr, 32'h40);
        check("stallredir_id_pc", id_pc, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("stallredir_target_pc", id_pc, 32'h40);
`endif

        // halt word at 0x14
        do_reset();
        rom[5] = HALT_WORD;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check("halt_id_pc", id_pc, 32'h14);
        check("halt_id_valid", 32'(id_valid), 32'd1);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_imem_addr", imem_addr, 32'h14);
        step(1'b0, 1'b0, 1'b1, 32'h40);
        check("halt_next_valid", 32'(id_valid), 32'd0);
        check("halt_frozen_addr", imem_addr, 32'h14);
        rom[5] = $urandom | 32'h8000_0000;

        // misaligned redirect
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h42);
        check("fault_fault", 32'(fault), 32'd1);
        check("fault_id_valid", 32'(id_valid), 32'd0);
        check("fault_imem_addr", imem_addr, 32'h4);
        step(1'b0, 1'b0, 1'b1, 32'h80);
        check("fault_held_addr", imem_addr, 32'h4);
        do_reset();

        // random phase
        fill_rom(24);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (((m_fault || m_halted) && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 3) == 0);
                fl = ($urandom_range(0, 9) == 0);
                rv = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 29) == 0) rp = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                else if ($urandom_range(0, 3) == 0) rp = $urandom & 32'hFFFF_FFFC;
                else rp = 32'($urandom_range(0, 63)) << 2;
                step(st, fl, rv, rp);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
